// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction memory read port, decode-side handshake,
// redirect input and the transfer counter.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] instr_count;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid, instr_count,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, instr_count,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetcher: FETCH issues a read, HOLD presents the
// instruction, DROP drains a request that a redirect has made stale.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] tgt;
    logic        ack;
    logic        unused_tgt_lsbs;

    assign tgt             = {bus.redirect_target[31:2], 2'b00};
    assign unused_tgt_lsbs = ^bus.redirect_target[1:0];
    // An ack only means something while our own request is on the bus.
    assign ack             = req_q & bus.imem_ack;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FETCH: begin
                if (bus.redirect) begin
                    pc_d    = tgt;
                    state_d = (req_q && !bus.imem_ack) ? DROP : FETCH;
                end else if (ack) begin
                    instr_d = bus.imem_rdata;
                    ipc_d   = pc_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ready) cnt_d = cnt_q + 32'd1;
                if (bus.redirect) begin
                    pc_d    = tgt;
                    state_d = FETCH;
                end else if (bus.instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (bus.redirect) pc_d = tgt;
                if (ack) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // DROP keeps the stale address on the bus until its ack returns.
        req_d   = (state_d != HOLD);
        valid_d = (state_d == HOLD);
        addr_d  = (state_d == DROP) ? addr_q : pc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= 32'd0;
            ipc_q   <= 32'd0;
            cnt_q   <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized and directed bench for instr_fetch_unit against a transaction-level model.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if fif();
    instr_fetch_if wif();

    instr_fetch_unit u_dut (.clk(clk), .rst(rst), .bus(fif));
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .rst(rst), .bus(wif));

    // Model: architectural next-fetch PC, what the bus should show, and whether
    // an in-flight read has been orphaned by a redirect.
    logic [31:0] m_pc, m_addr, m_instr, m_ipc, m_cnt;
    bit          m_req, m_valid, m_drop;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_cnt = 32'h0;
        m_req = 1'b0; m_valid = 1'b0; m_drop = 1'b0;
    endtask

    task automatic compare();
        chk("imem_req", 32'(fif.imem_req), 32'(m_req));
        chk("instr_valid", 32'(fif.instr_valid), 32'(m_valid));
        chk("instr_count", fif.instr_count, m_cnt);
        if (m_req) chk("imem_addr", fif.imem_addr, m_addr);
        if (m_valid) begin
            chk("instr", fif.instr, m_instr);
            chk("instr_pc", fif.instr_pc, m_ipc);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare.
    task automatic step(input bit ack, input logic [31:0] rdata, input bit ready,
                        input bit redir, input logic [31:0] tgt);
        logic [31:0] t;
        fif.imem_ack = ack; fif.imem_rdata = rdata; fif.instr_ready = ready;
        fif.redirect = redir; fif.redirect_target = tgt;
        t = {tgt[31:2], 2'b00};
        if (m_valid) begin
            if (ready) m_cnt = m_cnt + 32'd1;
            if (redir) begin m_pc = t; m_valid = 1'b0; end
            else if (ready) begin m_pc = m_pc + 32'd4; m_valid = 1'b0; end
            if (!m_valid) begin m_req = 1'b1; m_addr = m_pc; end
        end else if (m_drop) begin
            if (redir) m_pc = t;
            if (ack) begin m_drop = 1'b0; m_addr = m_pc; end
        end else if (m_req) begin
            if (redir) begin
                m_pc = t;
                if (!ack) m_drop = 1'b1; else m_addr = m_pc;
            end else if (ack) begin
                m_valid = 1'b1; m_req = 1'b0; m_instr = rdata; m_ipc = m_pc;
            end
        end else begin
            if (redir) m_pc = t;
            m_req = 1'b1; m_addr = m_pc;
        end
        @(negedge clk);
        compare();
    endtask

    initial begin
        wif.imem_ack = 1'b1; wif.imem_rdata = 32'h0000_0013; wif.instr_ready = 1'b1;
        wif.redirect = 1'b0; wif.redirect_target = 32'h0;
    end

    initial begin
        logic [31:0] held_i, held_pc;
        fif.imem_ack = 1'b0; fif.imem_rdata = 32'h0; fif.instr_ready = 1'b0;
        fif.redirect = 1'b0; fif.redirect_target = 32'h0;
        model_reset();
        #2;
        chk("rst imem_req", 32'(fif.imem_req), 32'h0);
        chk("rst instr_valid", 32'(fif.instr_valid), 32'h0);
        chk("rst instr", fif.instr, 32'h0);
        chk("rst instr_pc", fif.instr_pc, 32'h0);
        chk("rst instr_count", fif.instr_count, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // reset fetch
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("first req", 32'(fif.imem_req), 32'h1);
        chk("first addr", fif.imem_addr, 32'h0);
        chk("wrap first addr", wif.imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        chk("fetch valid", 32'(fif.instr_valid), 32'h1);
        chk("fetch instr", fif.instr, 32'h0000_0013);
        chk("fetch pc", fif.instr_pc, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("next addr", fif.imem_addr, 32'h4);
        chk("count after 1", fif.instr_count, 32'h1);
        chk("wrap next addr", wif.imem_addr, 32'h0);
        chk("wrap count", wif.instr_count, 32'h1);

        // backpressure
        step(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
        held_i = fif.instr; held_pc = fif.instr_pc;
        chk("bp instr", held_i, 32'h0050_0093);
        chk("bp pc", held_pc, 32'h4);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'hFFFF_0000, 1'b0, 1'b0, 32'h0);
            chk("bp stable instr", fif.instr, 32'h0050_0093);
            chk("bp stable pc", fif.instr_pc, 32'h4);
            chk("bp no req", 32'(fif.imem_req), 32'h0);
            chk("bp count", fif.instr_count, 32'h1);
        end

        // redirect in HOLD together with a transfer
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0103);
        chk("hold redir count", fif.instr_count, 32'h2);
        chk("hold redir addr", fif.imem_addr, 32'h0000_0100);
        chk("hold redir valid", 32'(fif.instr_valid), 32'h0);

        // redirect in FETCH, ack arrives three cycles later
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
        chk("drop old addr", fif.imem_addr, 32'h0000_0100);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        chk("drop valid", 32'(fif.instr_valid), 32'h0);
        chk("drop new addr", fif.imem_addr, 32'h0000_0200);
        step(1'b1, 32'h0000_0011, 1'b0, 1'b0, 32'h0);
        chk("post drop instr", fif.instr, 32'h0000_0011);
        chk("post drop pc", fif.instr_pc, 32'h0000_0200);

        // async reset while in DROP
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0300);
        chk("in drop addr", fif.imem_addr, 32'h0000_0204);
        #2 rst = 1'b1;
        #1;
        chk("async req", 32'(fif.imem_req), 32'h0);
        chk("async valid", 32'(fif.instr_valid), 32'h0);
        chk("async count", fif.instr_count, 32'h0);
        chk("async instr", fif.instr, 32'h0);
        fif.imem_ack = 1'b1; fif.imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 32'h0);
        chk("stale ignored addr", fif.imem_addr, 32'h0);
        chk("stale ignored valid", 32'(fif.instr_valid), 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 8), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset; bits [1:0] are zero.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: word-aligned read address, valid while imem_req=1.
REQ-006 The block SHALL have port imem_ack, input, 1 bit: read data valid this cycle; ignored while imem_req=0.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: read data, sampled when imem_req=1 and imem_ack=1.
REQ-008 The block SHALL have port instr, output, 32 bits: fetched instruction presented to main control decode.
REQ-009 The block SHALL have port instr_pc, output, 32 bits: address of the instruction on instr.
REQ-010 The block SHALL have port instr_valid, output, 1 bit: instr and instr_pc are valid.
REQ-011 The block SHALL have port instr_ready, input, 1 bit: the consumer accepts; a transfer occurs when instr_valid=1 and instr_ready=1.
REQ-012 The block SHALL have port redirect, input, 1 bit: control-flow change from branch or jump resolution.
REQ-013 The block SHALL have port redirect_target, input, 32 bits: new fetch address; bits [1:0] are ignored and treated as 00.
REQ-014 The block SHALL have port instr_count, output, 32 bits: number of completed transfers.

Function
REQ-015 The block SHALL implement FSM states FETCH, HOLD and DROP, plus a 32-bit PC register, a 32-bit instruction register and a 32-bit transfer counter.
REQ-016 In FETCH, imem_req=1 and imem_addr=PC; on imem_ack=1, the instruction register SHALL capture imem_rdata, instr_pc SHALL equal PC, and the state SHALL go to HOLD on the next edge.
REQ-017 In HOLD, instr_valid=1, imem_req=0, and instr and instr_pc SHALL stay stable until a transfer occurs.
REQ-018 On a transfer in HOLD without redirect, the block SHALL set PC to PC+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), increment instr_count, and go to FETCH.
REQ-019 In any state other than HOLD, instr_valid SHALL be 0.
REQ-020 On redirect=1 in HOLD, the block SHALL set PC to {redirect_target[31:2],2'b00}, drop instr_valid on the next cycle, and go to FETCH.
REQ-021 If a transfer coincides with redirect=1 in HOLD, the transfer SHALL count (instr_count increments) and PC SHALL take the redirect target, not PC+4.
REQ-022 On redirect=1 in FETCH with imem_ack=1 in the same cycle, the returned data SHALL be discarded, PC SHALL load the target, and the state SHALL stay FETCH.
REQ-023 On redirect=1 in FETCH with imem_ack=0, PC SHALL load the target and the state SHALL go to DROP.
REQ-024 In DROP, imem_req=1 and imem_addr SHALL hold the original (pre-redirect) address, so the outstanding request is not altered.
REQ-025 In DROP, the block SHALL discard the data on imem_ack=1 and then go to FETCH.
REQ-026 A further redirect in DROP SHALL overwrite PC with the newest target; the last redirect wins.
REQ-027 Latency SHALL be one cycle from an acked fetch to instr_valid=1, with zero-wait memory and continuous instr_ready giving one instruction per 2 cycles.
REQ-028 The block SHALL be fully synchronous apart from rst, and no output SHALL depend combinationally on imem_rdata.
REQ-029 instr_count SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-030 While rst=1, the block SHALL drive state=FETCH, PC=RESET_PC, instr=0, instr_pc=0, instr_valid=0 and instr_count=0; imem_req SHALL be 0 while rst is asserted.
REQ-031 Reset asserted mid-operation, including in DROP with a request outstanding, SHALL take effect immediately; any later imem_ack SHALL be ignored until imem_req=1 again.
REQ-032 On the first clk edge after rst deasserts, imem_req SHALL be 1 with imem_addr=RESET_PC.

Verification
REQ-033 Scenario "reset fetch": reset, zero-wait memory returning 32'h0000_0013 at 0, instr_ready=1 -> instr_valid=1 one cycle after ack, instr=32'h0000_0013, instr_pc=0; the next imem_addr is 4; instr_count=1.
REQ-034 Scenario "backpressure": instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc stay constant, imem_req=0, and instr_count does not change until instr_ready=1.
REQ-035 Scenario "redirect in HOLD": redirect_target=32'h0000_0103 together with a transfer -> instr_count increments and the next imem_addr=32'h0000_0100.
REQ-036 Scenario "redirect in FETCH": redirect with ack 3 cycles later, data 32'hDEAD_BEEF -> DEAD_BEEF is never presented, and the next request goes to the target.
REQ-037 Scenario "PC wrap": RESET_PC=32'hFFFF_FFFC, one transfer -> the next imem_addr=0.
REQ-038 Scenario "async reset in DROP": rst pulsed mid-cycle while in DROP -> outputs reach reset values before the next edge, and the stale ack is ignored.
